// File: rtl/memory_cycle_pkg.sv
// Shared definitions for the memory stage:
// FSM state encodings and the default access timeout.
package memory_cycle_pkg;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/memory_cycle_mw_reg.sv
// M/W pipeline register: bubble clears RegWrite and holds
// the payload, ReadData loads only on its enable.
module mw_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_bubble,
    input  logic              i_rdata_en,
    input  logic              i_reg_write,
    input  logic              i_result_src,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [DATA_W-1:0] i_pc_plus4,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_reg_write,
    output logic              o_result_src,
    output logic [REG_AW-1:0] o_rd,
    output logic [DATA_W-1:0] o_pc_plus4,
    output logic [DATA_W-1:0] o_alu_result,
    output logic [DATA_W-1:0] o_rdata
);

    logic              r_reg_write;
    logic              r_result_src;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_pc_plus4;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_rdata;

    // Control/payload fields: bubble inserts a no-write slot and keeps the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_result_src <= 1'b0;
            r_rd         <= '0;
            r_pc_plus4   <= '0;
            r_alu_result <= '0;
        end else if (i_bubble) begin
            r_reg_write  <= 1'b0;
        end else begin
            r_reg_write  <= i_reg_write;
            r_result_src <= i_result_src;
            r_rd         <= i_rd;
            r_pc_plus4   <= i_pc_plus4;
            r_alu_result <= i_alu_result;
        end
    end

    // Load data captured only when a load completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_rdata_en) begin
            r_rdata <= i_rdata;
        end
    end

    assign o_reg_write  = r_reg_write;
    assign o_result_src = r_result_src;
    assign o_rd         = r_rd;
    assign o_pc_plus4   = r_pc_plus4;
    assign o_alu_result = r_alu_result;
    assign o_rdata      = r_rdata;

endmodule

// File: rtl/memory_cycle.sv
// RV32I memory stage: req/ack data-memory access with
// wait counting, timeout abort, stall and M/W register.
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [REG_AW-1:0] RD_M,
    input  logic [DATA_W-1:0] PCPlus4M,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [DATA_W-1:0] ALU_ResultM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              StallM,
    output logic              mem_err,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [REG_AW-1:0] RD_W,
    output logic [DATA_W-1:0] PCPlus4W,
    output logic [DATA_W-1:0] ALU_ResultW,
    output logic [DATA_W-1:0] ReadDataW
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WCNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WCNT_ONE  = CW'(1);

    mem_state_e    r_state;
    mem_state_e    w_state_nxt;
    logic [CW-1:0] r_wcnt;
    logic [CW-1:0] w_wcnt_nxt;
    logic          r_mem_err;
    logic          w_access;
    logic          w_req;
    logic          w_done;
    logic          w_abort;
    logic          w_stall;

    assign w_access = MemWriteM | ResultSrcM;

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MEM_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // Next state, request, completion and timeout detection.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_req       = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            MEM_IDLE: begin
                w_req = w_access;
                if (w_access) begin
                    if (dmem_ack) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt = MEM_WAIT;
                        w_wcnt_nxt  = WCNT_ONE;
                    end
                end
            end
            MEM_WAIT: begin
                w_req = 1'b1;
                if (dmem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = MEM_IDLE;
                    w_wcnt_nxt  = '0;
                end else if (r_wcnt == WCNT_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = MEM_IDLE;
                    w_wcnt_nxt  = '0;
                end else begin
                    w_wcnt_nxt  = r_wcnt + WCNT_ONE;
                end
            end
            default: begin
                w_state_nxt = MEM_IDLE;
                w_wcnt_nxt  = '0;
            end
        endcase
    end

    // Timeout pulse appears the cycle after the abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= w_abort;
        end
    end

    assign w_stall    = dmem_req & ~dmem_ack & ~w_abort;
    assign dmem_req   = w_req & rst;
    assign dmem_we    = dmem_req & MemWriteM;
    assign dmem_addr  = ALU_ResultM;
    assign dmem_wdata = WriteDataM;
    assign StallM     = w_stall;
    assign mem_err    = r_mem_err;

    mw_pipe_reg #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_mw (
        .clk          (clk),
        .rst_n        (rst),
        .i_bubble     (w_stall | w_abort),
        .i_rdata_en   (w_done & ResultSrcM),
        .i_reg_write  (RegWriteM),
        .i_result_src (ResultSrcM),
        .i_rd         (RD_M),
        .i_pc_plus4   (PCPlus4M),
        .i_alu_result (ALU_ResultM),
        .i_rdata      (dmem_rdata),
        .o_reg_write  (RegWriteW),
        .o_result_src (ResultSrcW),
        .o_rd         (RD_W),
        .o_pc_plus4   (PCPlus4W),
        .o_alu_result (ALU_ResultW),
        .o_rdata      (ReadDataW)
    );

endmodule
